// File: rtl/color_centroid_tracker_pkg.sv
// Shared definitions for the colour centroid tracker: FSM state encoding,
// default raster geometry and the counter/accumulator width derivation.
package tracker_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // Pixel counter must hold a full frame of matches.
    function automatic int cnt_width(input int h, input int v);
        longint n;
        n = longint'(h) * longint'(v) + 1;
        return $clog2(n);
    endfunction

    // Coordinate sum must hold a full frame of the largest coordinate.
    function automatic int sum_width(input int h, input int v);
        longint m;
        longint n;
        m = (h > v) ? longint'(h) : longint'(v);
        n = longint'(h) * longint'(v) * (m - 1) + 1;
        return $clog2(n);
    endfunction

    localparam int CNT_W_DEF = cnt_width(H_ACTIVE_DEF, V_ACTIVE_DEF);
    localparam int SUM_W_DEF = sum_width(H_ACTIVE_DEF, V_ACTIVE_DEF);

    typedef enum logic [1:0] {
        IDLE_ACC = 2'd0,
        DIV_COL  = 2'd1,
        DIV_ROW  = 2'd2,
        PUBLISH  = 2'd3
    } state_t;

endpackage

// File: rtl/color_centroid_tracker_if.sv
// Pixel-stream inputs and published object statistics of the tracker.
// master = pixel source / result consumer, slave = the tracker itself.
interface color_centroid_tracker_if
    import tracker_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic [12:0]      row;
    logic [12:0]      col;
    logic             VGA_VS;
    logic             pix_match;
    logic             enable;

    logic [9:0]       obj_row;
    logic [9:0]       obj_col;
    logic [9:0]       bbox_rmin;
    logic [9:0]       bbox_rmax;
    logic [9:0]       bbox_cmin;
    logic [9:0]       bbox_cmax;
    logic [CNT_W-1:0] obj_count;
    logic             obj_valid;
    logic             frame_done;
    logic             overrun;

    modport master (
        output row, col, VGA_VS, pix_match, enable,
        input  obj_row, obj_col, bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax,
        input  obj_count, obj_valid, frame_done, overrun
    );

    modport slave (
        input  row, col, VGA_VS, pix_match, enable,
        output obj_row, obj_col, bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax,
        output obj_count, obj_valid, frame_done, overrun
    );

endinterface

// File: rtl/color_centroid_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. The first
// iteration runs on the start edge, so done pulses exactly SUM_W cycles
// after the start cycle with quotient/remainder already valid.
module seq_divider #(
    parameter int SUM_W = 28,
    parameter int CNT_W = 19
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [SUM_W-1:0] i_dividend,
    input  logic [CNT_W-1:0] i_divisor,
    output logic             o_done,
    output logic [SUM_W-1:0] o_quotient,
    output logic [CNT_W-1:0] o_remainder
);

    localparam int LEFT_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0]  r_quo;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_div;
    logic [LEFT_W-1:0] r_left;
    logic              r_busy;
    logic              r_done;

    logic [SUM_W-1:0]  w_q_in;
    logic [CNT_W-1:0]  w_r_in;
    logic [CNT_W-1:0]  w_d_in;
    logic [CNT_W:0]    w_shift;
    logic [CNT_W:0]    w_diff;
    logic              w_ge;
    logic [CNT_W-1:0]  w_r_nxt;
    logic [SUM_W-1:0]  w_q_nxt;

    // One restoring step; on start the operands come straight from the inputs.
    always_comb begin
        w_q_in  = i_start ? i_dividend : r_quo;
        w_r_in  = i_start ? '0 : r_rem;
        w_d_in  = i_start ? i_divisor : r_div;
        w_shift = {w_r_in, w_q_in[SUM_W-1]};
        w_diff  = w_shift - {1'b0, w_d_in};
        w_ge    = (w_shift >= {1'b0, w_d_in});
        w_r_nxt = w_ge ? w_diff[CNT_W-1:0] : w_shift[CNT_W-1:0];
        w_q_nxt = {w_q_in[SUM_W-2:0], w_ge};
    end

    // Iteration counter, partial remainder and quotient shift register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_left <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quo  <= w_q_nxt;
                r_rem  <= w_r_nxt;
                r_div  <= i_divisor;
                r_left <= LEFT_W'(SUM_W - 1);
                r_busy <= (SUM_W > 1);
                r_done <= (SUM_W == 1);
            end else if (r_busy) begin
                r_quo  <= w_q_nxt;
                r_rem  <= w_r_nxt;
                r_left <= r_left - LEFT_W'(1);
                if (r_left == LEFT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/color_centroid_tracker.sv
// Accumulates matched-pixel count, coordinate sums and bounding box per
// frame; at VS fall divides out the centroid and publishes the results,
// held stable until the next publish.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE_ACC | accumulating; waiting for frame end
//   DIV_COL  | dividing column sum by count
//   DIV_ROW  | dividing row sum by count
//   PUBLISH  | outputs just updated, frame_done high for this cycle
module color_centroid_tracker
    import tracker_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SUM_W      = SUM_W_DEF
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    color_centroid_tracker_if.slave  bus
);

    state_t           r_state;
    logic             r_vs_d;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sum_r;
    logic [SUM_W-1:0] r_sum_c;
    logic [9:0]       r_rmin, r_rmax, r_cmin, r_cmax;

    logic [CNT_W-1:0] r_sh_cnt;
    logic [SUM_W-1:0] r_sh_sum_r;
    logic [9:0]       r_sh_rmin, r_sh_rmax, r_sh_cmin, r_sh_cmax;

    logic [9:0]       r_q_col;
    logic             r_row_start;

    logic [9:0]       r_obj_row, r_obj_col;
    logic [9:0]       r_bbox_rmin, r_bbox_rmax, r_bbox_cmin, r_bbox_cmax;
    logic [CNT_W-1:0] r_obj_count;
    logic             r_obj_valid;
    logic             r_frame_done;
    logic             r_overrun;

    logic             w_fe;
    logic             w_hit;
    logic             w_snap_valid;
    logic [9:0]       w_row10, w_col10;
    logic             w_div_start;
    logic [SUM_W-1:0] w_dividend;
    logic [CNT_W-1:0] w_divisor;
    logic             w_div_done;
    logic [SUM_W-1:0] w_quo;
    logic [CNT_W-1:0] w_rem;
    logic             w_unused_div;

    assign w_row10      = bus.row[9:0];
    assign w_col10      = bus.col[9:0];
    assign w_fe         = r_vs_d & ~bus.VGA_VS;
    assign w_hit        = bus.enable & bus.pix_match &
                          (bus.row < 13'(V_ACTIVE)) & (bus.col < 13'(H_ACTIVE));
    assign w_snap_valid = (r_cnt >= CNT_W'(MIN_PIXELS));

    // Column division starts on the frame-end cycle from the live values,
    // which are exactly the snapshot being taken on that edge.
    assign w_div_start  = ((r_state == IDLE_ACC) && w_fe && w_snap_valid) || r_row_start;
    assign w_dividend   = r_row_start ? r_sh_sum_r : r_sum_c;
    assign w_divisor    = r_row_start ? r_sh_cnt   : r_cnt;
    assign w_unused_div = ^{w_quo[SUM_W-1:10], w_rem};

    seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .i_clk       (vga_clk),
        .i_rst_n     (reset_n),
        .i_start     (w_div_start),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Delayed VS for falling-edge detection; idles high so reset is not a frame end.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) r_vs_d <= 1'b1;
        else          r_vs_d <= bus.VGA_VS;
    end

    // Live accumulators; cleared at every frame end, with a same-cycle match
    // seeding the new frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_sum_r <= '0;
            r_sum_c <= '0;
            r_rmin  <= '1;
            r_rmax  <= '0;
            r_cmin  <= '1;
            r_cmax  <= '0;
        end else if (w_fe) begin
            r_cnt   <= w_hit ? CNT_W'(1) : '0;
            r_sum_r <= w_hit ? SUM_W'(bus.row) : '0;
            r_sum_c <= w_hit ? SUM_W'(bus.col) : '0;
            r_rmin  <= w_hit ? w_row10 : '1;
            r_rmax  <= w_hit ? w_row10 : '0;
            r_cmin  <= w_hit ? w_col10 : '1;
            r_cmax  <= w_hit ? w_col10 : '0;
        end else if (w_hit) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_sum_r <= r_sum_r + SUM_W'(bus.row);
            r_sum_c <= r_sum_c + SUM_W'(bus.col);
            if (w_row10 < r_rmin) r_rmin <= w_row10;
            if (w_row10 > r_rmax) r_rmax <= w_row10;
            if (w_col10 < r_cmin) r_cmin <= w_col10;
            if (w_col10 > r_cmax) r_cmax <= w_col10;
        end
    end

    // Frame sequencing FSM with snapshot registers and registered outputs.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE_ACC;
            r_sh_cnt     <= '0;
            r_sh_sum_r   <= '0;
            r_sh_rmin    <= '0;
            r_sh_rmax    <= '0;
            r_sh_cmin    <= '0;
            r_sh_cmax    <= '0;
            r_q_col      <= '0;
            r_row_start  <= 1'b0;
            r_obj_row    <= '0;
            r_obj_col    <= '0;
            r_bbox_rmin  <= '0;
            r_bbox_rmax  <= '0;
            r_bbox_cmin  <= '0;
            r_bbox_cmax  <= '0;
            r_obj_count  <= '0;
            r_obj_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_row_start  <= 1'b0;
            if (w_fe && (r_state != IDLE_ACC)) r_overrun <= 1'b1;

            case (r_state)
                IDLE_ACC: begin
                    if (w_fe) begin
                        r_sh_cnt   <= r_cnt;
                        r_sh_sum_r <= r_sum_r;
                        r_sh_rmin  <= r_rmin;
                        r_sh_rmax  <= r_rmax;
                        r_sh_cmin  <= r_cmin;
                        r_sh_cmax  <= r_cmax;
                        if (w_snap_valid) begin
                            r_state <= DIV_COL;
                        end else begin
                            // Too few pixels: publish count only, geometry holds.
                            r_obj_count  <= r_cnt;
                            r_obj_valid  <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= PUBLISH;
                        end
                    end
                end
                DIV_COL: begin
                    if (w_div_done) begin
                        r_q_col     <= w_quo[9:0];
                        r_row_start <= 1'b1;
                        r_state     <= DIV_ROW;
                    end
                end
                DIV_ROW: begin
                    if (w_div_done) begin
                        r_obj_row    <= w_quo[9:0];
                        r_obj_col    <= r_q_col;
                        r_bbox_rmin  <= r_sh_rmin;
                        r_bbox_rmax  <= r_sh_rmax;
                        r_bbox_cmin  <= r_sh_cmin;
                        r_bbox_cmax  <= r_sh_cmax;
                        r_obj_count  <= r_sh_cnt;
                        r_obj_valid  <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_state      <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    r_state <= IDLE_ACC;
                end
                default: begin
                    r_state <= IDLE_ACC;
                end
            endcase
        end
    end

    assign bus.obj_row    = r_obj_row;
    assign bus.obj_col    = r_obj_col;
    assign bus.bbox_rmin  = r_bbox_rmin;
    assign bus.bbox_rmax  = r_bbox_rmax;
    assign bus.bbox_cmin  = r_bbox_cmin;
    assign bus.bbox_cmax  = r_bbox_cmax;
    assign bus.obj_count  = r_obj_count;
    assign bus.obj_valid  = r_obj_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Directed bench for color_centroid_tracker: a pixel-level model builds the
// expected publish for each frame end and queues it; frame_done pops it.
module tb_color_centroid_tracker;
    import tracker_pkg::*;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int MINP = 64;
    localparam int CW   = 19;
    localparam int SW   = 28;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;

    color_centroid_tracker_if #(.CNT_W(CW)) bus ();

    color_centroid_tracker #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .MIN_PIXELS (MINP),
        .CNT_W      (CW),
        .SUM_W      (SW)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int count;
        int valid;
        int orow, ocol, rmin, rmax, cmin, cmax;
        int fe_idx;
        int lat;
    } exp_t;

    exp_t   q[$];
    exp_t   m_e;

    int     m_cnt, m_rmin, m_rmax, m_cmin, m_cmax;
    longint m_sr, m_sc;
    int     h_orow, h_ocol, h_rmin, h_rmax, h_cmin, h_cmax;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic m_clear();
        m_cnt = 0; m_sr = 0; m_sc = 0;
        m_rmin = 1023; m_rmax = 0; m_cmin = 1023; m_cmax = 0;
    endtask

    task automatic m_add(input int r, input int c, input bit m);
        if (bus.enable && m && r < V && c < H) begin
            m_cnt++; m_sr += r; m_sc += c;
            if (r < m_rmin) m_rmin = r;
            if (r > m_rmax) m_rmax = r;
            if (c < m_cmin) m_cmin = c;
            if (c > m_cmax) m_cmax = c;
        end
    endtask

    task automatic drive(input int r, input int c, input bit m);
        @(posedge vga_clk); #1;
        bus.row = 13'(r); bus.col = 13'(c); bus.pix_match = m; bus.VGA_VS = 1'b1;
        m_add(r, c, m);
    endtask

    task automatic block(input int r0, input int nr, input int c0, input int nc);
        for (int r = r0; r < r0 + nr; r++)
            for (int c = c0; c < c0 + nc; c++)
                drive(r, c, 1'b1);
    endtask

    // VS falls for two cycles; optional match on the fe cycle itself.
    task automatic vs_fall(input bit publish, input bit m, input int r, input int c);
        exp_t e;
        @(posedge vga_clk); #1;
        bus.VGA_VS = 1'b0; bus.row = 13'(r); bus.col = 13'(c); bus.pix_match = m;
        if (publish) begin
            e.fe_idx = cyc;
            e.count  = m_cnt;
            e.valid  = (m_cnt >= MINP) ? 1 : 0;
            if (e.valid == 1) begin
                h_orow = int'(m_sr / longint'(m_cnt));
                h_ocol = int'(m_sc / longint'(m_cnt));
                h_rmin = m_rmin; h_rmax = m_rmax; h_cmin = m_cmin; h_cmax = m_cmax;
                e.lat  = 2 * SW + 2;
            end else begin
                e.lat  = 1;
            end
            e.orow = h_orow; e.ocol = h_ocol;
            e.rmin = h_rmin; e.rmax = h_rmax; e.cmin = h_cmin; e.cmax = h_cmax;
            q.push_back(e);
        end
        m_clear();
        m_add(r, c, m);
        @(posedge vga_clk); #1;
        bus.pix_match = 1'b0;
        @(posedge vga_clk); #1;
        bus.VGA_VS = 1'b1;
    endtask

    task automatic wait_q(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(posedge vga_clk);
            n++;
        end
        chk("publish_timeout", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_obj_row"},    bus.obj_row,    0);
        chk({tag, "_obj_col"},    bus.obj_col,    0);
        chk({tag, "_rmin"},       bus.bbox_rmin,  0);
        chk({tag, "_rmax"},       bus.bbox_rmax,  0);
        chk({tag, "_cmin"},       bus.bbox_cmin,  0);
        chk({tag, "_cmax"},       bus.bbox_cmax,  0);
        chk({tag, "_count"},      bus.obj_count,  0);
        chk({tag, "_valid"},      bus.obj_valid,  0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_overrun"},    bus.overrun,    0);
    endtask

    // Scoreboard: every frame_done pulse must match the oldest queued frame.
    always @(negedge vga_clk) begin
        if (bus.frame_done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                m_e = q.pop_front();
                chk("latency",   cyc - m_e.fe_idx, m_e.lat);
                chk("obj_count", bus.obj_count,    m_e.count);
                chk("obj_valid", bus.obj_valid,    m_e.valid);
                chk("obj_row",   bus.obj_row,      m_e.orow);
                chk("obj_col",   bus.obj_col,      m_e.ocol);
                chk("bbox_rmin", bus.bbox_rmin,    m_e.rmin);
                chk("bbox_rmax", bus.bbox_rmax,    m_e.rmax);
                chk("bbox_cmin", bus.bbox_cmin,    m_e.cmin);
                chk("bbox_cmax", bus.bbox_cmax,    m_e.cmax);
            end
        end
    end

    initial begin
        bus.row = '0; bus.col = '0; bus.VGA_VS = 1'b1; bus.pix_match = 1'b0; bus.enable = 1'b1;
        m_clear();
        h_orow = 0; h_ocol = 0; h_rmin = 0; h_rmax = 0; h_cmin = 0; h_cmax = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // 10x10 block -> centroid 104/204
        block(100, 10, 200, 10);
        vs_fall(1'b1, 1'b0, 0, 0);
        wait_q(80);
        chk("overrun_idle", bus.overrun, 0);

        // empty frame -> invalid, geometry held
        repeat (5) drive(0, 0, 1'b0);
        vs_fall(1'b1, 1'b0, 0, 0);
        wait_q(10);

        // 63 pixels -> invalid; the fe-cycle match seeds the next frame
        block(50, 7, 60, 9);
        vs_fall(1'b1, 1'b1, 20, 30);
        wait_q(10);

        // 1 + 63 = 64 pixels -> valid at the threshold
        block(20, 7, 30, 9);
        vs_fall(1'b1, 1'b0, 0, 0);
        wait_q(80);

        // out-of-window and disabled matches only
        drive(100, 700, 1'b1);
        drive(500, 100, 1'b1);
        drive(480, 0, 1'b1);
        drive(0, 640, 1'b1);
        drive(0, 0, 1'b0);
        bus.enable = 1'b0;
        block(10, 4, 10, 4);
        drive(0, 0, 1'b0);
        bus.enable = 1'b1;
        vs_fall(1'b1, 1'b0, 0, 0);
        wait_q(10);

        // second VS fall while dividing -> overrun, interim pixels dropped
        block(100, 10, 200, 10);
        vs_fall(1'b1, 1'b0, 0, 0);
        block(5, 1, 5, 10);
        repeat (5) drive(0, 0, 1'b0);
        vs_fall(1'b0, 1'b0, 0, 0);
        chk("overrun_set", bus.overrun, 1);
        block(300, 8, 10, 8);
        drive(479, 639, 1'b1);
        vs_fall(1'b1, 1'b0, 0, 0);
        wait_q(100);
        chk("overrun_sticky", bus.overrun, 1);

        // reset during the row division
        block(200, 4, 300, 16);
        vs_fall(1'b1, 1'b0, 0, 0);
        repeat (38) @(posedge vga_clk);
        #1;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk_zero("mid_div_reset");
        m_clear();
        h_orow = 0; h_ocol = 0; h_rmin = 0; h_rmax = 0; h_cmin = 0; h_cmax = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        repeat (70) drive(0, 0, 1'b0);
        chk("post_reset_count", bus.obj_count, 0);

        // full frame after reset
        block(400, 10, 600, 10);
        vs_fall(1'b1, 1'b0, 0, 0);
        wait_q(80);
        chk("overrun_after_reset", bus.overrun, 0);

        repeat (5) @(posedge vga_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
